// File: rtl/cg_history_pingpong_buffer.sv
// cg_history_pingpong_buffer: two-bank CG previous-vector store with a sequenced stream reader.
// Optional CG_HISTORY_VALID_MASK_EN: per-bank written-masks, so unwritten words read back as zero.
module cg_history_pingpong_buffer #(
   parameter int element_width = 32,
   parameter int no_of_units   = 8,
   parameter int memory_height = 1000,
   parameter int address_width = $clog2(memory_height)+1
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset,
   input  logic                                 i_wr_en,
   input  logic [address_width-1:0]             i_wr_addr,
   input  logic [element_width*no_of_units-1:0] i_wr_data,
   input  logic                                 i_rd_en,
   input  logic [address_width-1:0]             i_rd_addr,
   input  logic                                 i_stream_start,
   input  logic [31:0]                          i_stream_len,
   input  logic                                 i_stream_hold,
   input  logic                                 i_swap,
   output logic [element_width*no_of_units-1:0] o_rd_data,
   output logic                                 o_rd_valid,
   output logic [address_width-1:0]             o_rd_addr_out,
   output logic                                 o_stream_busy,
   output logic                                 o_stream_done,
   output logic                                 o_bank_sel,
   output logic                                 o_swap_pending,
   output logic [31:0]                          o_iter_count,
   output logic                                 o_err_sticky
);
   localparam int dw = element_width*no_of_units;
   localparam int iw = $clog2(memory_height);
   localparam logic [address_width-1:0] c_height = address_width'(memory_height);
   localparam logic [31:0] c_height32 = 32'(memory_height);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t                   r_state;
   logic [dw-1:0]            r_mem [2][memory_height];
   logic [address_width-1:0] r_addr, r_last, r_rd_addr;
   logic [dw-1:0]            r_rd_data;
   logic [31:0]              r_iter;
   logic                     r_bank_sel, r_pending, r_busy, r_done, r_err, r_rd_valid;

   logic                     w_rbank, w_wr_ok, w_rd_rand, w_rd_strm, w_issue, w_err, w_do_swap;
   logic [address_width-1:0] w_raddr, w_last;
   logic [dw-1:0]            w_mem_word, w_rword;

   assign w_rbank    = ~r_bank_sel;
   assign w_wr_ok    = i_wr_en && (i_wr_addr < c_height);
   assign w_rd_rand  = (r_state == IDLE) && i_rd_en && (i_rd_addr < c_height);
   assign w_rd_strm  = (r_state == STREAM) && !i_stream_hold;
   assign w_issue    = w_rd_rand || w_rd_strm;
   assign w_raddr    = w_rd_strm ? r_addr : i_rd_addr;
   assign w_mem_word = r_mem[w_rbank][w_raddr[iw-1:0]];
   assign w_last     = (i_stream_len > c_height32) ? c_height - 1'b1 : address_width'(i_stream_len - 32'd1);
   assign w_err      = (i_wr_en && !(i_wr_addr < c_height))
                    || (i_rd_en && (r_state == IDLE) && !(i_rd_addr < c_height))
                    || (i_rd_en && (r_state == STREAM))
                    || (i_stream_start && (r_state != IDLE));
   // a deferred swap lands in the stream_done cycle; a fresh swap there merges into the same one
   assign w_do_swap  = r_done ? (r_pending || i_swap) : ((r_state == IDLE) && i_swap);

`ifdef CG_HISTORY_VALID_MASK_EN
   logic [memory_height-1:0] r_mask [2];
   assign w_rword = r_mask[w_rbank][w_raddr[iw-1:0]] ? w_mem_word : '0;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_mask[0] <= '0;
         r_mask[1] <= '0;
      end else begin
         if (w_do_swap) r_mask[w_rbank] <= '0;
         if (w_wr_ok) r_mask[r_bank_sel][i_wr_addr[iw-1:0]] <= 1'b1;
      end
`else
   assign w_rword = w_mem_word;
`endif

   always_ff @(posedge i_clk)
      if (w_wr_ok) r_mem[r_bank_sel][i_wr_addr[iw-1:0]] <= i_wr_data;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_last     <= '0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_iter     <= '0;
         r_bank_sel <= 1'b0;
         r_pending  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE:
               if (i_stream_start) begin
                  r_state <= (i_stream_len != 32'd0) ? STREAM : IDLE;
                  r_busy  <= (i_stream_len != 32'd0);
                  r_done  <= (i_stream_len == 32'd0);
                  r_addr  <= '0;
                  r_last  <= w_last;
               end
            STREAM:
               if (!i_stream_hold) begin
                  r_addr <= r_addr + 1'b1;
                  if (r_addr == r_last) begin
                     r_state <= DRAIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            default: r_state <= IDLE;
         endcase
         r_rd_valid <= w_issue;
         if (w_issue) begin
            r_rd_data <= w_rword;
            r_rd_addr <= w_raddr;
         end
         r_err     <= r_err || w_err;
         r_pending <= w_do_swap ? 1'b0 : (r_pending || (i_swap && r_busy));
         if (w_do_swap) begin
            r_bank_sel <= ~r_bank_sel;
            r_iter     <= r_iter + 32'd1;
         end
      end

   assign o_rd_data      = r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_rd_addr_out  = r_rd_addr;
   assign o_stream_busy  = r_busy;
   assign o_stream_done  = r_done;
   assign o_bank_sel     = r_bank_sel;
   assign o_swap_pending = r_pending;
   assign o_iter_count   = r_iter;
   assign o_err_sticky   = r_err;
endmodule
